// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory access stage.
//   - access size encodings used on req_size
//   - FSM state encoding for mem_access_unit
//   - exception codes produced by the stage
//   - isMisaligned() helper, only consulted when MEM_MISALIGN_EXC_EN is defined
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [7:0] EXC_NONE     = 8'h00;
  localparam logic [7:0] EXC_MISALIGN = 8'h84;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A byte can never be misaligned; size encoding 3 behaves like a word.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
    logic result;
    case (size)
      SZ_BYTE: result = 1'b0;
      SZ_HALF: result = offset[0];
      default: result = (offset != 2'b00);
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: combinational little-endian byte-lane formatter.
//   Store side: byte enables and lane-replicated write data from size/offset.
//   Load side : selects the addressed lane of a bus word and sign- or
//               zero-extends it to 32 bits.
// Ports:
//   size_i    access size (SZ_BYTE/SZ_HALF/SZ_WORD, 3 acts as word)
//   offset_i  low two address bits
//   signed_i  sign-extend sub-word loads
//   wdata_i   right-aligned store data
//   rdata_i   raw bus read word
//   be_o      byte enables for a store
//   wdata_o   lane-replicated store data
//   rdata_o   extracted and extended load data
module mem_lane_fmt
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size_i,
  input  logic [1:0]        offset_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [3:0]        be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  // Lane selection ignores address bits below the access size, so a half
  // access only looks at offset_i[1].
  always_comb begin
    lane8  = rdata_i[7:0];
    lane16 = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (offset_i)
      2'd0:    lane8 = rdata_i[7:0];
      2'd1:    lane8 = rdata_i[15:8];
      2'd2:    lane8 = rdata_i[23:16];
      default: lane8 = rdata_i[31:24];
    endcase
  end

  // Size decides enables, replication and the extension width.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{signed_i & lane8[7]}}, lane8};
      end
      SZ_HALF: begin
        be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{signed_i & lane16[15]}}, lane16};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage behind the TLB.
//   Accepts a translated physical address plus data-side exception code,
//   performs a byte/half/word load or store over a req/ack bus, stalls the
//   pipeline while the access is outstanding and returns extended load data
//   with a one-cycle resp_valid strobe. A nonzero exc_in turns the access into
//   a raw word read of the vector-table address.
// Configuration macro: MEM_MISALIGN_EXC_EN
//   defined   - misaligned half/word accesses skip the bus and report 8'h84
//   undefined - low address bits below the access size are ignored
// Ports:
//   clk, rst_n, clk_en                       clock, async active-low reset, enable
//   req_valid, req_write, req_size,
//   req_signed, paddr, exc_in, wdata         request from the pipeline
//   stall, resp_valid, rdata, exc_out        pipeline control and response
//   mem_req, mem_we, mem_addr, mem_wdata,
//   mem_be, mem_ack, mem_rdata               physical memory bus
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        exc_in,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic [7:0]        exc_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        offset_q, offset_d;
  logic              signed_q, signed_d;
  logic [7:0]        exc_q, exc_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0]        fmtSize;
  logic [1:0]        fmtOffset;
  logic [3:0]        fmtBe;
  logic [DATA_W-1:0] fmtWdata;
  logic [DATA_W-1:0] fmtRdata;

  // The single formatter serves the incoming request while idle (store
  // lanes) and the registered request while busy (load extraction).
  assign fmtSize   = (state_q == ST_IDLE) ? req_size    : size_q;
  assign fmtOffset = (state_q == ST_IDLE) ? paddr[1:0]  : offset_q;

  mem_lane_fmt #(
    .DATA_W (DATA_W)
  ) u_lane_fmt (
    .size_i   (fmtSize),
    .offset_i (fmtOffset),
    .signed_i (signed_q),
    .wdata_i  (wdata),
    .rdata_i  (mem_rdata),
    .be_o     (fmtBe),
    .wdata_o  (fmtWdata),
    .rdata_o  (fmtRdata)
  );

  // Next-state logic: accept in IDLE, wait for ack in BUSY, one response
  // cycle in DONE. Requests seen in DONE belong to the departing op.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    size_d   = size_q;
    offset_d = offset_q;
    signed_d = signed_q;
    exc_d    = exc_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d   = req_size;
          offset_d = paddr[1:0];
          signed_d = req_signed;
          exc_d    = exc_in;
          addr_d   = {paddr[ADDR_W-1:2], 2'b00};
          wdata_d  = fmtWdata;
          state_d  = ST_BUSY;
          if (exc_in != EXC_NONE) begin
            // Vector fetch: always a full-word read, never a write.
            we_d = 1'b0;
            be_d = 4'b1111;
          end else begin
            we_d = req_write;
            be_d = req_write ? fmtBe : 4'b1111;
`ifdef MEM_MISALIGN_EXC_EN
            if (isMisaligned(req_size, paddr[1:0])) begin
              we_d    = 1'b0;
              exc_d   = EXC_MISALIGN;
              rdata_d = '0;
              state_d = ST_DONE;
            end
`endif
          end
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          rdata_d = (exc_q != EXC_NONE) ? mem_rdata : fmtRdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Everything holds while clk_en is low, including an ack on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 4'b0000;
      size_q   <= SZ_BYTE;
      offset_q <= 2'b00;
      signed_q <= 1'b0;
      exc_q    <= EXC_NONE;
      rdata_q  <= '0;
    end else if (clk_en) begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      size_q   <= size_d;
      offset_q <= offset_d;
      signed_q <= signed_d;
      exc_q    <= exc_d;
      rdata_q  <= rdata_d;
    end
  end

  // stall is combinational so the accept cycle already holds upstream;
  // gating with rst_n keeps it low for the whole reset window.
  assign stall      = rst_n & (((state_q == ST_IDLE) & req_valid) | (state_q == ST_BUSY));
  assign resp_valid = (state_q == ST_DONE);
  assign mem_req    = (state_q == ST_BUSY);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_be     = be_q;
  assign rdata      = rdata_q;
  assign exc_out    = exc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed-vector bench for mem_access_unit.
//   Stimulus pushes the expected response into a scoreboard queue; a monitor
//   pops and compares whenever resp_valid is seen. Bus-side values and stall
//   timing are compared inline by the stimulus task.
//   Honours MEM_MISALIGN_EXC_EN for the misaligned-word vector.
module tb_mem_access_unit;

  typedef struct packed {
    logic [31:0] rdata;
    logic [7:0]  exc;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [26:0] paddr;
  logic [7:0]  exc_in;
  logic [31:0] wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] rdata;
  logic [7:0]  exc_out;
  logic        mem_req;
  logic        mem_we;
  logic [26:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  resp_t sb[$];
  int    total = 0;
  int    bad   = 0;

  mem_access_unit #(
    .ADDR_W (27),
    .DATA_W (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .paddr      (paddr),
    .exc_in     (exc_in),
    .wdata      (wdata),
    .stall      (stall),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .exc_out    (exc_out),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, actual, expected);
    end
  endfunction

  // Monitor: every response strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedResp: got rdata=0x%08h exc=0x%02h want no response",
                 rdata, exc_out);
      end else begin
        resp_t exp;
        exp = sb.pop_front();
        checkOutput("respRdata", rdata, exp.rdata);
        checkOutput("respExc", {24'h0, exc_out}, {24'h0, exp.exc});
      end
    end
  end

  // One complete bus transaction. busyCycles counts the BUSY cycles up to and
  // including the ack cycle; enHold drops clk_en for that many cycles with
  // ack already asserted.
  task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sgn,
                               input logic [26:0] pa, input logic [7:0] exc,
                               input logic [31:0] wd, input logic [31:0] busData,
                               input int busyCycles, input int enHold,
                               input logic [31:0] expRdata, input logic [7:0] expExc,
                               input logic [3:0] expBe, input logic [31:0] expWdata,
                               input logic expWe, input logic [26:0] expAddr);
    int stallCount;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sgn;
    paddr      = pa;
    exc_in     = exc;
    wdata      = wd;
    sb.push_back('{rdata: expRdata, exc: expExc});
    #1;
    checkOutput("acceptStall", {31'h0, stall}, 32'h1);
    stallCount = int'(stall);
    for (int i = 0; i < busyCycles; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req_valid = 1'b0;
        #1;
        checkOutput("busReq", {31'h0, mem_req}, 32'h1);
        checkOutput("busWe", {31'h0, mem_we}, {31'h0, expWe});
        checkOutput("busAddr", {5'h0, mem_addr}, {5'h0, expAddr});
        checkOutput("busBe", {28'h0, mem_be}, {28'h0, expBe});
        if (expWe) checkOutput("busWdata", mem_wdata, expWdata);
      end
      stallCount += int'(stall);
      if (i == busyCycles - 1) begin
        mem_ack   = 1'b1;
        mem_rdata = busData;
        if (enHold > 0) clk_en = 1'b0;
      end
    end
    for (int h = 0; h < enHold; h++) begin
      @(negedge clk);
      #1;
      checkOutput("holdReq", {31'h0, mem_req}, 32'h1);
      checkOutput("holdResp", {31'h0, resp_valid}, 32'h0);
    end
    clk_en = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    #1;
    checkOutput("doneStall", {31'h0, stall}, 32'h0);
    checkOutput("doneReq", {31'h0, mem_req}, 32'h0);
    checkOutput("stallCycles", stallCount, busyCycles + 1);
    @(negedge clk);
    #1;
    checkOutput("respPulse", {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    clk_en     = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    paddr      = 27'h0;
    exc_in     = 8'h0;
    wdata      = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rstStall", {31'h0, stall}, 32'h0);
    checkOutput("rstResp", {31'h0, resp_valid}, 32'h0);
    checkOutput("rstReq", {31'h0, mem_req}, 32'h0);
    checkOutput("rstWe", {31'h0, mem_we}, 32'h0);
    checkOutput("rstRdata", rdata, 32'h0);
    checkOutput("rstAddr", {5'h0, mem_addr}, 32'h0);
    checkOutput("rstWdata", mem_wdata, 32'h0);
    checkOutput("rstBe", {28'h0, mem_be}, 32'h0);
    checkOutput("rstExc", {24'h0, exc_out}, 32'h0);
    rst_n = 1'b1;

    $display("[TB] byte store, ack after 3 cycles");
    applyStimulus(1'b1, 2'd0, 1'b0, 27'h0000102, 8'h00, 32'h000000AB, 32'h0, 3, 0,
                  32'h0, 8'h00, 4'b0100, 32'hABABABAB, 1'b1, 27'h0000100);

    $display("[TB] signed and unsigned half loads");
    applyStimulus(1'b0, 2'd1, 1'b1, 27'h0000006, 8'h00, 32'h0, 32'h80FF1234, 1, 0,
                  32'hFFFF80FF, 8'h00, 4'b1111, 32'h0, 1'b0, 27'h0000004);
    applyStimulus(1'b0, 2'd1, 1'b0, 27'h0000006, 8'h00, 32'h0, 32'h80FF1234, 2, 0,
                  32'h000080FF, 8'h00, 4'b1111, 32'h0, 1'b0, 27'h0000004);

    $display("[TB] exception store becomes vector word read");
    applyStimulus(1'b1, 2'd0, 1'b0, 27'h0000208, 8'h82, 32'h00000055, 32'hDEADBEEF, 2, 0,
                  32'hDEADBEEF, 8'h82, 4'b1111, 32'h0, 1'b0, 27'h0000208);

    $display("[TB] signed byte load, half store, size-3 store");
    applyStimulus(1'b0, 2'd0, 1'b1, 27'h0000001, 8'h00, 32'h0, 32'h00008000, 1, 0,
                  32'hFFFFFF80, 8'h00, 4'b1111, 32'h0, 1'b0, 27'h0000000);
    applyStimulus(1'b1, 2'd1, 1'b0, 27'h000000A, 8'h00, 32'h12345678, 32'h0, 1, 0,
                  32'h0, 8'h00, 4'b1100, 32'h56785678, 1'b1, 27'h0000008);
    applyStimulus(1'b1, 2'd3, 1'b0, 27'h0000010, 8'h00, 32'hCAFEF00D, 32'h0, 1, 0,
                  32'h0, 8'h00, 4'b1111, 32'hCAFEF00D, 1'b1, 27'h0000010);

    $display("[TB] clk_en low for 5 cycles with ack held");
    applyStimulus(1'b0, 2'd2, 1'b0, 27'h0000020, 8'h00, 32'h0, 32'h12345678, 2, 5,
                  32'h12345678, 8'h00, 4'b1111, 32'h0, 1'b0, 27'h0000020);

    $display("[TB] reset during BUSY");
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd2;
    paddr     = 27'h0000040;
    exc_in    = 8'h00;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    checkOutput("preRstReq", {31'h0, mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstReq", {31'h0, mem_req}, 32'h0);
    checkOutput("midRstStall", {31'h0, stall}, 32'h0);
    checkOutput("midRstResp", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 27'h0000043, 8'h00, 32'h0, 32'hA1B2C3D4, 1, 0,
                  32'h000000A1, 8'h00, 4'b1111, 32'h0, 1'b0, 27'h0000040);

    $display("[TB] misaligned word load");
`ifdef MEM_MISALIGN_EXC_EN
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd2;
    paddr     = 27'h0000003;
    exc_in    = 8'h00;
    sb.push_back('{rdata: 32'h0, exc: 8'h84});
    #1;
    checkOutput("misStall", {31'h0, stall}, 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    checkOutput("misReq", {31'h0, mem_req}, 32'h0);
    checkOutput("misResp", {31'h0, resp_valid}, 32'h1);
    @(negedge clk);
`else
    applyStimulus(1'b0, 2'd2, 1'b0, 27'h0000003, 8'h00, 32'h0, 32'h11223344, 1, 0,
                  32'h11223344, 8'h00, 4'b1111, 32'h0, 1'b0, 27'h0000000);
`endif

    repeat (2) @(negedge clk);
    checkOutput("sbEmpty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
